// File: rtl/stream_demux.sv
// stream_demux: registered 1-to-N demultiplexer with valid/ready on input and each output.
// One holding register is shared by all channels. A pending mask tracks which channels
// are still owed the current word; broadcast words stay up until every channel takes them.
// Optional feature (macro STREAM_DEMUX_CNT_EN): per-channel 8-bit saturating transfer
// counters on port cnt, with synchronous clear input clr_cnt.
module stream_demux #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned N_CH  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [WIDTH-1:0]        in_data,
    input  logic [$clog2(N_CH)-1:0] in_sel,
    input  logic                    in_bcast,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [N_CH*WIDTH-1:0]   out_data,
    output logic [N_CH-1:0]         out_valid,
    input  logic [N_CH-1:0]         out_ready,
`ifdef STREAM_DEMUX_CNT_EN
    input  logic                    clr_cnt,
    output logic [N_CH*8-1:0]       cnt,
`endif
    output logic                    sel_err
);

    localparam int unsigned SEL_W = $clog2(N_CH);

    logic [WIDTH-1:0] data_q, data_d;
    logic [N_CH-1:0]  pend_q, pend_d;
    logic             sel_err_q, sel_err_d;
    logic [N_CH-1:0]  out_xfer;
    logic             in_xfer;
    logic [N_CH-1:0]  sel_onehot;
    logic             sel_in_range;

    // Accept a new word when every still-pending channel is taking the old one this cycle.
    assign in_ready     = ((pend_q & ~out_ready) == '0);
    assign in_xfer      = in_valid & in_ready;
    assign out_xfer     = pend_q & out_ready;
    assign sel_onehot   = {{(N_CH-1){1'b0}}, 1'b1} << in_sel;
    // Only reachable as false when N_CH is not a power of two.
    assign sel_in_range = (32'(in_sel) < N_CH);

    assign out_valid = pend_q;
    assign out_data  = {N_CH{data_q}};
    assign sel_err   = sel_err_q;

    // Next-state: retire accepted channels, then load a new word over the top if accepted.
    always_comb begin
        data_d    = data_q;
        pend_d    = pend_q & ~out_xfer;
        sel_err_d = 1'b0;
        if (in_xfer) begin
            data_d = in_data;
            if (in_bcast) begin
                pend_d = '1;
            end else if (sel_in_range) begin
                pend_d = sel_onehot;
            end else begin
                // Word is consumed but delivered nowhere.
                pend_d    = '0;
                sel_err_d = 1'b1;
            end
        end
    end

    // Holding register, pending mask and error pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q    <= '0;
            pend_q    <= '0;
            sel_err_q <= 1'b0;
        end else begin
            data_q    <= data_d;
            pend_q    <= pend_d;
            sel_err_q <= sel_err_d;
        end
    end

`ifdef STREAM_DEMUX_CNT_EN
    logic [N_CH-1:0][7:0] cnt_q, cnt_d;

    // Per-channel saturating counters; clear takes priority over increment.
    always_comb begin
        cnt_d = cnt_q;
        for (int unsigned k = 0; k < N_CH; k++) begin
            if (clr_cnt) begin
                cnt_d[k] = 8'd0;
            end else if (out_xfer[k] && (cnt_q[k] != 8'hFF)) begin
                cnt_d[k] = cnt_q[k] + 8'd1;
            end
        end
    end

    // Counter state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
`endif

    // SEL_W documents the select width; in_sel is declared with the same expression.
    logic unused_sel_w;
    assign unused_sel_w = ^SEL_W;

endmodule
